// File: rtl/seq_det_arbiter_pkg.sv
// seq_det_arbiter_pkg
// Shared definitions for the round-robin "11010" counting arbiter:
//   - arb_state_e : top-level arbiter FSM encoding (IDLE / SHIFT / DONE)
//   - det_state_e : Gray-coded 3-bit encoding of the Mealy pattern detector
//   - PATTERN     : the bit pattern recognised, MSB is the first bit seen
//   - sat_inc     : 2-bit saturating increment for the running match count
package seq_det_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } arb_state_e;

  // Gray sequence: each forward step along the pattern flips a single bit.
  typedef enum logic [2:0] {
    DET_IDLE    = 3'b000,
    DET_GOT1    = 3'b001,
    DET_GOT11   = 3'b011,
    DET_GOT110  = 3'b010,
    DET_GOT1101 = 3'b110
  } det_state_e;

  localparam logic [4:0] PATTERN = 5'b11010;

  function automatic logic [1:0] sat_inc(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

endpackage

// File: rtl/seq_det_arbiter_core.sv
// seq_det_core
// Mealy recogniser for the non-overlapping pattern 11010, fed one bit per
// enabled cycle.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   clr          : synchronous return to the idle state (wins over en)
//   en           : d_in is valid this cycle; state advances on the edge
//   d_in         : serial input bit
//   match        : combinational, high when d_in completes the pattern
module seq_det_core
  import seq_det_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  input  logic d_in,
  output logic match
);

  det_state_e state_q, state_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= DET_IDLE;
    else          state_q <= state_d;
  end

  // Each state expects the next pattern bit; on a miss fall back to the
  // longest prefix that is still a suffix of what has been seen.
  always_comb begin
    state_d = state_q;
    match   = 1'b0;
    if (clr) begin
      state_d = DET_IDLE;
    end else if (en) begin
      case (state_q)
        DET_IDLE:    state_d = (d_in == PATTERN[4]) ? DET_GOT1    : DET_IDLE;
        DET_GOT1:    state_d = (d_in == PATTERN[3]) ? DET_GOT11   : DET_IDLE;
        DET_GOT11:   state_d = (d_in == PATTERN[2]) ? DET_GOT110  : DET_GOT11;
        DET_GOT110:  state_d = (d_in == PATTERN[1]) ? DET_GOT1101 : DET_IDLE;
        DET_GOT1101: begin
          if (d_in == PATTERN[0]) begin
            match   = 1'b1;
            state_d = DET_IDLE;      // non-overlapping: restart from scratch
          end else begin
            state_d = DET_GOT11;     // "11011" still ends in "11"
          end
        end
        default:     state_d = DET_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/seq_det_arbiter.sv
// seq_det_arbiter
// Round-robin arbiter over N_REQ requesters. The winner's WIDTH-bit word is
// shifted MSB first through a "11010" detector; the number of matches
// (saturating at 3) is reported with a one-cycle done/ack pulse.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   req [N_REQ]   : request levels, held until ack
//   data          : packed words, slice i = data[i*WIDTH +: WIDTH]
//   gnt [N_REQ]   : one-hot grant for the whole SHIFT + DONE window
//   ack [N_REQ]   : one-cycle completion pulse to the winner
//   busy          : FSM not in IDLE
//   done          : one-cycle completion pulse (same cycle as ack)
//   match_cnt     : match count of the last completed word, held
//   match_id      : requester index that match_cnt belongs to
//   dbg_state     : current arbiter FSM state
//
// Handshake: a requester raises req and keeps it high; the block samples req
// only in IDLE, and the word is consumed when ack pulses. Changes to req or
// data while busy are ignored. A req still high after ack is a new request.
module seq_det_arbiter
  import seq_det_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 16,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
)(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   done,
  output logic [1:0]             match_cnt,
  output logic [IDX_W-1:0]       match_id,
  output logic [1:0]             dbg_state
);

  localparam int BIT_W = $clog2(WIDTH + 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [1:0]       run_cnt_q, run_cnt_d;
  logic [1:0]       match_cnt_q, match_cnt_d;
  logic [IDX_W-1:0] match_id_q, match_id_d;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic [N_REQ-1:0] pick_oh;
  logic [WIDTH-1:0] pick_word;
  logic             det_clr, det_en, det_match;

  // Round-robin search: first asserted req at or above ptr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
    pick_oh   = '0;
    pick_word = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        pick_oh[k] = 1'b1;
        pick_word  = data[k*WIDTH +: WIDTH];
      end
    end
  end

  seq_det_core u_det (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (det_clr),
    .en      (det_en),
    .d_in    (shift_q[WIDTH-1]),
    .match   (det_match)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    gnt_d       = gnt_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    run_cnt_d   = run_cnt_q;
    match_cnt_d = match_cnt_q;
    match_id_d  = match_id_q;
    // Detector is parked idle while waiting, so each word starts clean.
    det_clr     = (state_q == ST_IDLE);
    det_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d   = ST_SHIFT;
          winner_d  = pick_idx;
          gnt_d     = pick_oh;
          shift_d   = pick_word;
          bit_cnt_d = '0;
          run_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        det_en    = 1'b1;
        shift_d   = shift_q << 1;
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (det_match) run_cnt_d = sat_inc(run_cnt_q);
        if (bit_cnt_q == BIT_W'(WIDTH - 1)) begin
          // run_cnt_d already includes a match on the LSB.
          state_d     = ST_DONE;
          match_cnt_d = run_cnt_d;
          match_id_d  = winner_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        ptr_d   = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      gnt_q       <= '0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      run_cnt_q   <= '0;
      match_cnt_q <= '0;
      match_id_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      gnt_q       <= gnt_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      run_cnt_q   <= run_cnt_d;
      match_cnt_q <= match_cnt_d;
      match_id_q  <= match_id_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = (state_q == ST_DONE);
  assign ack       = done ? gnt_q : '0;
  assign busy      = (state_q != ST_IDLE);
  assign match_cnt = match_cnt_q;
  assign match_id  = match_id_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_det_arbiter.sv
module tb_seq_det_arbiter;

  localparam int N_REQ = 4;
  localparam int WIDTH = 16;
  localparam int IDX_W = 2;
  localparam int EW    = N_REQ + IDX_W + 2;

  logic                   clk;
  logic                   reset_n;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] data;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       ack;
  logic                   busy;
  logic                   done;
  logic [1:0]             match_cnt;
  logic [IDX_W-1:0]       match_id;
  logic [1:0]             dbg_state;

  seq_det_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .match_cnt (match_cnt),
    .match_id  (match_id),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference count: greedy left-to-right scan for non-overlapping 11010.
  function automatic logic [1:0] model_cnt(input logic [WIDTH-1:0] w);
    int c = 0;
    int i = WIDTH - 1;
    while (i >= 4) begin
      if (w[i -: 5] == 5'b11010) begin
        c++;
        i -= 5;
      end else begin
        i--;
      end
    end
    return (c > 3) ? 2'd3 : 2'(c);
  endfunction

  function automatic logic [EW-1:0] pack_exp(input int idx, input logic [1:0] cnt);
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return {oh, IDX_W'(idx), cnt};
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got id %0d cnt %0d, expected no done", match_id, match_cnt);
      end else begin
        exp_e = exp_q.pop_front();
        check("done_result{ack,id,cnt}", 32'({ack, match_id, match_cnt}), 32'(exp_e));
        check("gnt_during_done", 32'(gnt), 32'(ack));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (done !== 1'b1 && n < 60);
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic do_txn(input int idx, input logic [WIDTH-1:0] word, input logic [1:0] exp_cnt);
    int n;
    logic gnt_ok;
    logic [N_REQ-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    @(negedge clk);
    data[idx*WIDTH +: WIDTH] = word;
    req = oh;
    exp_q.push_back(pack_exp(idx, exp_cnt));
    gnt_ok = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (done !== 1'b1 && gnt !== oh) gnt_ok = 1'b0;
    end while (done !== 1'b1 && n < 60);
    check("latency_edges", 32'(n), 32'(WIDTH + 1));
    check("gnt_held", 32'(gnt_ok), 32'd1);
    req = '0;
    @(posedge clk); #1;
    check("idle_after_done{busy,gnt,ack,done}", 32'({busy, gnt, ack, done}), 32'd0);
    check("match_cnt_held", 32'(match_cnt), 32'(exp_cnt));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int               idx;
    logic [WIDTH-1:0] word;
    logic [1:0]       cnt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int n;
    logic [WIDTH-1:0] w;
    int ri;

    vecs[0] = '{0, 16'hD6B4, 2'd3};
    vecs[1] = '{1, 16'hFFFF, 2'd0};
    vecs[2] = '{2, 16'h001A, 2'd1};   // match on the LSB
    vecs[3] = '{3, 16'h0000, 2'd0};
    vecs[4] = '{0, 16'h1A1A, 2'd2};
    vecs[5] = '{1, 16'h6800, 2'd1};
    vecs[6] = '{2, 16'hD01A, 2'd2};
    vecs[7] = '{3, 16'h5555, 2'd0};
    vecs[8] = '{1, 16'h000D, 2'd0};   // ends in 1101 ...
    vecs[9] = '{1, 16'h4000, 2'd0};   // ... next starts with 0: no cross-word match

    reset_n = 1'b0;
    req     = '0;
    data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({gnt, ack, done, busy, match_cnt, match_id, dbg_state}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int v = 0; v < 10; v++) do_txn(vecs[v].idx, vecs[v].word, vecs[v].cnt);

    // random words against the reference counter
    for (int r = 0; r < 6; r++) begin
      ri = $urandom_range(0, N_REQ - 1);
      w  = WIDTH'($urandom);
      do_txn(ri, w, model_cnt(w));
    end

    // data/req changes while busy are ignored
    @(negedge clk);
    data[0 +: WIDTH] = 16'hD6B4;
    req = 4'b0001;
    exp_q.push_back(pack_exp(0, 2'd3));
    repeat (5) @(posedge clk);
    #1;
    data[0 +: WIDTH] = 16'h0000;
    req = 4'b0000;
    wait_done(n);
    check("ignore_changes_id", 32'(match_id), 32'd0);
    @(posedge clk); #1;

    // all four requesting: round-robin from pointer 0
    apply_reset();
    @(negedge clk);
    data = {16'h1A1A, 16'h001A, 16'hFFFF, 16'hD6B4};
    req  = 4'b1111;
    exp_q.push_back(pack_exp(0, 2'd3));
    exp_q.push_back(pack_exp(1, 2'd0));
    exp_q.push_back(pack_exp(2, 2'd1));
    exp_q.push_back(pack_exp(3, 2'd2));
    for (int k = 0; k < 4; k++) begin
      wait_done(n);
      check("rr_order", 32'(match_id), 32'(k));
      @(posedge clk); #1;
      req[k] = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    check("rr_idle_busy", 32'(busy), 32'd0);

    // reset in the middle of SHIFT aborts the word
    apply_reset();
    @(negedge clk);
    data[0 +: WIDTH] = 16'hD000;
    req = 4'b0001;
    repeat (9) @(posedge clk);
    #1;
    check("mid_shift_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_outputs", 32'({gnt, ack, done, busy, match_cnt, match_id, dbg_state}), 32'd0);
    @(negedge clk);
    req = 4'b1000;
    data[3*WIDTH +: WIDTH] = 16'h001A;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    exp_q.push_back(pack_exp(3, 2'd1));
    wait_done(n);
    check("post_abort_latency", 32'(n), 32'(WIDTH + 1));
    check("post_abort_id", 32'(match_id), 32'd3);
    req = '0;
    @(posedge clk); #1;

    // requester 0 held, requester 2 raised mid-word: order 0, 2, 0
    apply_reset();
    @(negedge clk);
    data[0 +: WIDTH] = 16'h001A;
    data[2*WIDTH +: WIDTH] = 16'hD6B4;
    req = 4'b0001;
    exp_q.push_back(pack_exp(0, 2'd1));
    repeat (5) @(posedge clk);
    #1;
    req = 4'b0101;
    exp_q.push_back(pack_exp(2, 2'd3));
    exp_q.push_back(pack_exp(0, 2'd1));
    wait_done(n);
    check("late_req_first", 32'(match_id), 32'd0);
    wait_done(n);
    check("late_req_second", 32'(match_id), 32'd2);
    req = 4'b0001;
    wait_done(n);
    check("late_req_third", 32'(match_id), 32'd0);
    req = '0;
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", 32'({busy, gnt}), 32'd0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
